// File: rtl/rgb_to_gray_pkg.sv
// Shared definitions for the RGB-to-grayscale controller slice.
// Holds the FSM state encoding, the channel/gain select codes used by both
// the controller and the datapath, and the settle counter width.
package rgb_to_gray_pkg;

  localparam int unsigned SEL_W    = 2;
  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_TURN = 3'd1,
    G_TURN = 3'd2,
    B_TURN = 3'd3,
    RESULT = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_R    = 2'd0;
  localparam sel_t SEL_G    = 2'd1;
  localparam sel_t SEL_B    = 2'd2;
  localparam sel_t SEL_NONE = 2'd3;

  // Channel/gain code driven in a given state; only turn states select a channel.
  function automatic sel_t turn_sel(input state_e s);
    case (s)
      R_TURN:  return SEL_R;
      G_TURN:  return SEL_G;
      B_TURN:  return SEL_B;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rgb_to_gray_ctrl_if.sv
// Pixel-side handshake bundle of the controller.
//   in_valid  : source has R/G/B stable on the datapath inputs
//   in_ready  : controller can accept a pixel
//   out_valid : GRAY register holds the result of the accepted pixel
//   out_ready : sink consumes GRAY
// master = source/sink side, slave = controller side.
interface rgb_to_gray_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/rgb_to_gray_settle_cnt.sv
// Loadable 4-bit down-counter shared by the three turn stages.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val (takes priority over dec)
//   dec        : decrement, saturating at zero
//   load_val   : reload value
//   zero_c     : count is zero (combinational from the count register)
module rgb_to_gray_settle_cnt
  import rgb_to_gray_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                dec,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero_c
);

  logic [SETTLE_W-1:0] count;

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/rgb_to_gray_ctrl.sv
// Sequencing FSM for the RGB-to-grayscale float datapath, one pixel at a time.
// Accepts a pixel on the in handshake, steps the datapath through the R, G and
// B product stages and the GRAY sum, then holds GRAY until the sink takes it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pix                 : in/out valid-ready handshake (slave modport)
//   busy                : high in every state except IDLE
//   load_reg_en         : datapath input register load (IDLE & in_valid)
//   r/g/b_turn_reg_en   : datapath product register loads
//   result_reg_en       : datapath GRAY register load
//   channel_mux/gain_mux: select codes (0=R, 1=G, 2=B, 3=none)
//   pix_count           : completed-pixel counter, RGB2GRAY_PIXCNT_EN builds only
// Optional feature macro: RGB2GRAY_PIXCNT_EN (adds CNT_W and pix_count).
// Outputs are decoded from the state register; load_reg_en additionally
// depends on in_valid so the datapath captures R/G/B on the accepting edge.
module rgb_to_gray_ctrl
  import rgb_to_gray_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 0
`ifdef RGB2GRAY_PIXCNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  rgb_to_gray_ctrl_if.slave pix,
  output logic             busy,
  output logic             load_reg_en,
  output logic             r_turn_reg_en,
  output logic             g_turn_reg_en,
  output logic             b_turn_reg_en,
  output logic             result_reg_en,
  output logic [SEL_W-1:0] channel_mux,
  output logic [SEL_W-1:0] gain_mux
`ifdef RGB2GRAY_PIXCNT_EN
  ,
  output logic [CNT_W-1:0] pix_count
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

  state_e state;
  state_e state_nxt;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  // Settle counter: reloaded on entry to every turn stage
  rgb_to_gray_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (SETTLE_LD),
    .zero_c   (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt     = state;
    pix.in_ready  = 1'b0;
    pix.out_valid = 1'b0;
    busy          = 1'b1;
    load_reg_en   = 1'b0;
    r_turn_reg_en = 1'b0;
    g_turn_reg_en = 1'b0;
    b_turn_reg_en = 1'b0;
    result_reg_en = 1'b0;
    channel_mux   = turn_sel(state);
    gain_mux      = turn_sel(state);
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    case (state)
      IDLE: begin
        pix.in_ready = 1'b1;
        busy         = 1'b0;
        if (pix.in_valid) begin
          load_reg_en = 1'b1;
          cnt_load    = 1'b1;
          state_nxt   = R_TURN;
        end
      end
      R_TURN: begin
        if (cnt_zero) begin
          r_turn_reg_en = 1'b1;
          cnt_load      = 1'b1;
          state_nxt     = G_TURN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      G_TURN: begin
        if (cnt_zero) begin
          g_turn_reg_en = 1'b1;
          cnt_load      = 1'b1;
          state_nxt     = B_TURN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      B_TURN: begin
        if (cnt_zero) begin
          b_turn_reg_en = 1'b1;
          state_nxt     = RESULT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESULT: begin
        result_reg_en = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        pix.out_valid = 1'b1;
        if (pix.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef RGB2GRAY_PIXCNT_EN
  // Completed-pixel counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count <= '0;
    end else if ((state == DONE) && pix.out_ready) begin
      pix_count <= pix_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rgb_to_gray_ctrl.sv
// Self-checking bench for rgb_to_gray_ctrl. Two instances run side by side,
// SETTLE_CYCLES = 0 and 3. A small integer stand-in for the float datapath
// follows the controller's enables and mux selects; the expected GRAY of each
// accepted pixel comes from the weighted-sum rule and is queued by the driver,
// the monitor pops and compares on every out handshake.
module tb_rgb_to_gray_ctrl;
  import rgb_to_gray_pkg::*;

  localparam int unsigned NI = 2;
  localparam int unsigned CW = 2;
  localparam int PH_DIR    = 0;
  localparam int PH_RAND   = 1;
  localparam int PH_STALL  = 2;
  localparam int PH_B2B    = 3;

  typedef struct packed {
    logic [31:0] gray;
    logic [31:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] in_valid = '0;
  logic [NI-1:0] out_ready = '0;
  logic [NI-1:0] in_ready, out_valid, busy;
  logic [NI-1:0] load_en, r_en, g_en, b_en, res_en;
  logic [NI-1:0][1:0] ch_mux, gn_mux;
  logic [NI-1:0][7:0] r_in, g_in, b_in;
`ifdef RGB2GRAY_PIXCNT_EN
  logic [NI-1:0][CW-1:0] pix_count;
  logic [CW-1:0] pc_model [NI];
`endif

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned S = (gi == 0) ? 0 : 3;
    rgb_to_gray_ctrl_if ifc ();
    assign ifc.in_valid  = in_valid[gi];
    assign ifc.out_ready = out_ready[gi];
    assign in_ready[gi]  = ifc.in_ready;
    assign out_valid[gi] = ifc.out_valid;

    rgb_to_gray_ctrl #(
      .SETTLE_CYCLES (S)
`ifdef RGB2GRAY_PIXCNT_EN
      , .CNT_W (CW)
`endif
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pix           (ifc),
      .busy          (busy[gi]),
      .load_reg_en   (load_en[gi]),
      .r_turn_reg_en (r_en[gi]),
      .g_turn_reg_en (g_en[gi]),
      .b_turn_reg_en (b_en[gi]),
      .result_reg_en (res_en[gi]),
      .channel_mux   (ch_mux[gi]),
      .gain_mux      (gn_mux[gi])
`ifdef RGB2GRAY_PIXCNT_EN
      , .pix_count   (pix_count[gi])
`endif
    );
  end

  // Reference rules
  function automatic int unsigned settle_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int unsigned lat_of(input int i);
    return 3 * (settle_of(i) + 1) + 2;
  endfunction

  function automatic int unsigned gray_ref(input int unsigned r, input int unsigned g,
                                           input int unsigned b);
    return 77 * r + 150 * g + 29 * b;
  endfunction

  // One datapath multiplier: selected channel times selected gain
  function automatic int unsigned term(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b, input logic [1:0] ch,
                                       input logic [1:0] gn);
    int unsigned c, k;
    case (ch)
      2'd0: c = r;
      2'd1: c = g;
      2'd2: c = b;
      default: c = 0;
    endcase
    case (gn)
      2'd0: k = 77;
      2'd1: k = 150;
      2'd2: k = 29;
      default: k = 0;
    endcase
    return c * k;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb [NI][$];
  int   phase = PH_DIR;
  bit   stall_check = 1'b0;
  bit   final_check = 1'b0;
  bit   found_b = 1'b0;

  // Monitor-owned state
  int n_chk = 0;
  int n_pass = 0;
  int viol_oh = 0, viol_busy = 0, viol_load = 0, viol_stab = 0;
  logic [7:0]  dr [NI], dg [NI], db [NI];
  int unsigned rp [NI], gp [NI], bp [NI], gray_m [NI], held_gray [NI];
  int          er [NI], eg [NI], eb [NI], eres [NI];
  int          last_acc [NI], acc_stall [NI];
  bit          ov_prev [NI], hs_pend [NI], acc_b2b [NI], rst_seen [NI];
  bit          fin_done = 1'b0;

  function automatic void chk(input int inst, input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] @cyc %0d: got 0x%0h, expected 0x%0h", name, inst, cyc, act, exp);
  endfunction

  // Monitor: datapath stand-in, protocol checks and scoreboard comparisons
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int unsigned prod;
      exp_t e;
      if (!rst_n) begin
        if (!rst_seen[i]) begin
          rst_seen[i] = 1'b1;
          chk(i, "reset_outputs",
              64'({in_ready[i], out_valid[i], busy[i], load_en[i], r_en[i], g_en[i],
                   b_en[i], res_en[i], ch_mux[i], gn_mux[i]}),
              64'({1'b1, 7'b0, SEL_NONE, SEL_NONE}));
        end
        sb[i].delete();
        ov_prev[i] = 1'b0;
        hs_pend[i] = 1'b0;
        acc_b2b[i] = 1'b0;
`ifdef RGB2GRAY_PIXCNT_EN
        pc_model[i] = '0;
`endif
        continue;
      end
      rst_seen[i] = 1'b0;

      if ($countones({load_en[i], r_en[i], g_en[i], b_en[i], res_en[i]}) > 1) viol_oh++;
      if (busy[i] == in_ready[i]) viol_busy++;
      if (load_en[i] != (in_valid[i] & in_ready[i])) viol_load++;

      if (hs_pend[i]) begin
        hs_pend[i] = 1'b0;
        chk(i, "after_handshake", 64'({out_valid[i], in_ready[i]}), 64'(2'b01));
`ifdef RGB2GRAY_PIXCNT_EN
        chk(i, "pix_count", 64'(pix_count[i]), 64'(pc_model[i]));
`endif
      end

      if (load_en[i]) begin
        dr[i] = r_in[i]; dg[i] = g_in[i]; db[i] = b_in[i];
        er[i] = 0; eg[i] = 0; eb[i] = 0; eres[i] = 0;
      end
      prod = term(dr[i], dg[i], db[i], ch_mux[i], gn_mux[i]);
      if (r_en[i]) begin rp[i] = prod; er[i]++; end
      if (g_en[i]) begin gp[i] = prod; eg[i]++; end
      if (b_en[i]) begin bp[i] = prod; eb[i]++; end
      if (res_en[i]) begin gray_m[i] = rp[i] + gp[i] + bp[i]; eres[i]++; end

      if (in_valid[i] && in_ready[i]) begin
        if (phase == PH_B2B && acc_b2b[i])
          chk(i, "accept_period", 64'(cyc - last_acc[i]), 64'(lat_of(i) + 1));
        acc_b2b[i]  = (phase == PH_B2B);
        last_acc[i] = cyc;
        if (phase == PH_STALL) acc_stall[i]++;
      end

      if (out_valid[i]) begin
        if (!ov_prev[i]) begin
          chk(i, "pending_pixel", 64'(sb[i].size() != 0), 64'(1));
          if (sb[i].size() != 0)
            chk(i, "latency", 64'(32'(cyc) - sb[i][0].acc), 64'(lat_of(i)));
          chk(i, "enable_counts", 64'({4'(er[i]), 4'(eg[i]), 4'(eb[i]), 4'(eres[i])}),
              64'(16'h1111));
          held_gray[i] = gray_m[i];
        end else if (gray_m[i] != held_gray[i]) begin
          viol_stab++;
        end
        if (out_ready[i] && sb[i].size() != 0) begin
          e = sb[i].pop_front();
          chk(i, "gray", 64'(gray_m[i]), 64'(e.gray));
          hs_pend[i] = 1'b1;
`ifdef RGB2GRAY_PIXCNT_EN
          pc_model[i] = pc_model[i] + CW'(1);
`endif
        end
      end

      if (stall_check) begin
        chk(i, "stall_accepts", 64'(acc_stall[i]), 64'(1));
        chk(i, "stall_out_valid", 64'({out_valid[i], in_ready[i]}), 64'(2'b10));
        acc_stall[i] = 0;
      end
      ov_prev[i] = out_valid[i];
    end

    if (final_check && !fin_done) begin
      fin_done = 1'b1;
      chk(0, "onehot_violations", 64'(viol_oh), 64'(0));
      chk(0, "busy_ready_violations", 64'(viol_busy), 64'(0));
      chk(0, "load_violations", 64'(viol_load), 64'(0));
      chk(0, "gray_stability_violations", 64'(viol_stab), 64'(0));
      for (int i = 0; i < NI; i++) chk(i, "scoreboard_empty", 64'(sb[i].size()), 64'(0));
      chk(1, "b_turn_seen", 64'(found_b), 64'(1));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  // One stimulus cycle: drive after the edge, record acceptances before the next
  task automatic step(input int ph, input logic [NI-1:0] iv, input logic [NI-1:0] ordy,
                      input bit rnd, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    @(posedge clk);
    #1;
    phase     = ph;
    in_valid  = iv;
    out_ready = ordy;
    for (int i = 0; i < NI; i++) begin
      r_in[i] = rnd ? 8'($urandom) : r;
      g_in[i] = rnd ? 8'($urandom) : g;
      b_in[i] = rnd ? 8'($urandom) : b;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      if (rst_n && in_valid[i] && in_ready[i])
        sb[i].push_back({32'(gray_ref(r_in[i], g_in[i], b_in[i])), 32'(cyc)});
  endtask

  task automatic idle_steps(input int n, input logic [NI-1:0] ordy);
    for (int k = 0; k < n; k++) step(PH_DIR, '0, ordy, 1'b1, 8'd0, 8'd0, 8'd0);
  endtask

  // Driver
  initial begin
    r_in = '0; g_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    step(PH_DIR, '1, '1, 1'b0, 8'd0, 8'd0, 8'd0);
    idle_steps(20, '1);
    step(PH_DIR, '1, '1, 1'b0, 8'd255, 8'd0, 8'd0);
    idle_steps(20, '1);

    for (int k = 0; k < 600; k++)
      step(PH_RAND, NI'($urandom), NI'($urandom | $urandom), 1'b1, 8'd0, 8'd0, 8'd0);
    idle_steps(30, '1);

    // Sink stalls while the source keeps offering pixels
    for (int k = 0; k < 40; k++) step(PH_STALL, '1, '0, 1'b1, 8'd0, 8'd0, 8'd0);
    @(posedge clk); #1 stall_check = 1'b1;
    @(posedge clk); #1 stall_check = 1'b0;
    idle_steps(30, '1);

    for (int k = 0; k < 60; k++) step(PH_B2B, '1, '1, 1'b1, 8'd0, 8'd0, 8'd0);
    idle_steps(30, '1);

    // Reset in the middle of B_TURN of the SETTLE_CYCLES=3 instance
    step(PH_DIR, '1, '1, 1'b1, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 40 && !found_b; k++) begin
      step(PH_DIR, '0, '1, 1'b1, 8'd0, 8'd0, 8'd0);
      if (ch_mux[1] == SEL_B) found_b = 1'b1;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_steps(20, '1);

    for (int k = 0; k < 200; k++)
      step(PH_RAND, NI'($urandom), NI'($urandom), 1'b1, 8'd0, 8'd0, 8'd0);
    idle_steps(40, '1);

    @(posedge clk); #1 final_check = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL end_of_test: monitor did not close the run");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
